pl_mem_wb: RTL and testbench

//  MEM/WB stage: consumer of the EX-stage pipeline register. Executes loads/stores over a
//  req/ack data-memory handshake, writes ALU or load results to the register file, and

---
 rtl/pl_pkg.sv | 24 ++
 rtl/pl_mem_wb.sv | 189 ++++++++++++++++++
 tb/tb_pl_mem_wb.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pl_pkg.sv
// Shared definitions for the MEM/WB stage: EX-register bit indices, FSM encoding, data-width helper.
package pl_pkg;

  localparam int unsigned LANE_W = 8;

  localparam int unsigned EX_STORE     = 0;
  localparam int unsigned EX_REG_WR    = 1;
  localparam int unsigned EX_SAVE_COUT = 2;
  localparam int unsigned EX_INV_EX    = 3;
  localparam int unsigned EX_LOAD      = 4;
  localparam int unsigned EX_INV_FETCH = 5;
  localparam int unsigned EX_INV_DEC   = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  function automatic int unsigned dw_of(input int unsigned num_domains);
    return num_domains * LANE_W;
  endfunction

endpackage

// File: rtl/pl_mem_wb.sv
// MEM/WB pipeline stage: load/store over a req/ack memory port, register-file writeback, carry flag.
// Optional ack timeout enabled by defining PL_MEMWB_TIMEOUT_EN.
module pl_mem_wb
  import pl_pkg::*;
#(
  parameter int unsigned NUM_DOMAINS = 1,
  parameter int unsigned TIMEOUT_CYC = 16,
  localparam int unsigned DW = dw_of(NUM_DOMAINS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [0:6]    ex_reg,
  input  logic [DW-1:0] ex_result,
  input  logic [2:0]    ex_dest_addr,
  input  logic [7:0]    ex_wr_addr,
  input  logic [7:0]    ex_rd_addr,
  input  logic          ex_cout,
  output logic          mem_req,
  output logic          mem_we,
  output logic [7:0]    mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          rf_wr_en,
  output logic [2:0]    rf_wr_addr,
  output logic [DW-1:0] rf_wr_data,
  output logic          carry_flag,
  output logic          stall,
  output logic          mem_err
);

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  state_e          state_q, state_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [7:0]      addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [2:0]      dest_q, dest_d;
  logic            rf_wr_en_q, rf_wr_en_d;
  logic [2:0]      rf_wr_addr_q, rf_wr_addr_d;
  logic [DW-1:0]   rf_wr_data_q, rf_wr_data_d;
  logic            carry_q, carry_d;
  logic            stall_q, stall_d;
  logic            ex_valid_c;

`ifdef PL_MEMWB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  assign ex_valid_c = !(ex_reg[EX_INV_EX] | ex_reg[EX_INV_FETCH] | ex_reg[EX_INV_DEC]);

  // Next-state and next-output logic; ex_* only looked at while idle.
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    dest_d       = dest_q;
    rf_wr_en_d   = 1'b0;
    rf_wr_addr_d = rf_wr_addr_q;
    rf_wr_data_d = rf_wr_data_q;
    carry_d      = carry_q;
`ifdef PL_MEMWB_TIMEOUT_EN
    cnt_d        = cnt_q;
    err_d        = err_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
`ifdef PL_MEMWB_TIMEOUT_EN
        cnt_d = '0;
`endif
        if (ex_valid_c) begin
          if (ex_reg[EX_SAVE_COUT]) carry_d = ex_cout;
          if (ex_reg[EX_STORE]) begin
            state_d = ST_MEM;
            req_d   = 1'b1;
            we_d    = 1'b1;
            addr_d  = ex_wr_addr;
            wdata_d = ex_result;
          end else if (ex_reg[EX_LOAD]) begin
            state_d = ST_MEM;
            req_d   = 1'b1;
            we_d    = 1'b0;
            addr_d  = ex_rd_addr;
            dest_d  = ex_dest_addr;
          end else if (ex_reg[EX_REG_WR]) begin
            rf_wr_en_d   = 1'b1;
            rf_wr_addr_d = ex_dest_addr;
            rf_wr_data_d = ex_result;
          end
        end
      end

      ST_MEM: begin
        if (mem_ack) begin
          req_d = 1'b0;
          if (we_q) begin
            state_d = ST_IDLE;
          end else begin
            // Write strobe lands in the WB cycle, one cycle after the ack cycle.
            state_d      = ST_WB;
            rf_wr_en_d   = 1'b1;
            rf_wr_addr_d = dest_q;
            rf_wr_data_d = mem_rdata;
          end
        end
`ifdef PL_MEMWB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end

      ST_WB: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase

    stall_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= 8'd0;
      wdata_q      <= '0;
      dest_q       <= 3'd0;
      rf_wr_en_q   <= 1'b0;
      rf_wr_addr_q <= 3'd0;
      rf_wr_data_q <= '0;
      carry_q      <= 1'b0;
      stall_q      <= 1'b0;
`ifdef PL_MEMWB_TIMEOUT_EN
      cnt_q        <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      dest_q       <= dest_d;
      rf_wr_en_q   <= rf_wr_en_d;
      rf_wr_addr_q <= rf_wr_addr_d;
      rf_wr_data_q <= rf_wr_data_d;
      carry_q      <= carry_d;
      stall_q      <= stall_d;
`ifdef PL_MEMWB_TIMEOUT_EN
      cnt_q        <= cnt_d;
      err_q        <= err_d;
`endif
    end
  end

  assign mem_req    = req_q;
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign rf_wr_en   = rf_wr_en_q;
  assign rf_wr_addr = rf_wr_addr_q;
  assign rf_wr_data = rf_wr_data_q;
  assign carry_flag = carry_q;
  assign stall      = stall_q;
`ifdef PL_MEMWB_TIMEOUT_EN
  assign mem_err    = err_q;
`else
  assign mem_err    = 1'b0;
`endif

endmodule

// File: tb/tb_pl_mem_wb.sv
// Directed bench for pl_mem_wb: ALU writeback, load, store, invalid, carry, reset mid-access, timeout.
`timescale 1ns/1ps
module tb_pl_mem_wb;
  import pl_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [0:6] ex_reg;
  logic [7:0] ex_result;
  logic [2:0] ex_dest_addr;
  logic [7:0] ex_wr_addr;
  logic [7:0] ex_rd_addr;
  logic       ex_cout;
  logic       mem_req;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       mem_ack;
  logic       rf_wr_en;
  logic [2:0] rf_wr_addr;
  logic [7:0] rf_wr_data;
  logic       carry_flag;
  logic       stall;
  logic       mem_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pl_mem_wb #(.NUM_DOMAINS(1), .TIMEOUT_CYC(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .ex_reg       (ex_reg),
    .ex_result    (ex_result),
    .ex_dest_addr (ex_dest_addr),
    .ex_wr_addr   (ex_wr_addr),
    .ex_rd_addr   (ex_rd_addr),
    .ex_cout      (ex_cout),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack),
    .rf_wr_en     (rf_wr_en),
    .rf_wr_addr   (rf_wr_addr),
    .rf_wr_data   (rf_wr_data),
    .carry_flag   (carry_flag),
    .stall        (stall),
    .mem_err      (mem_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic [0:6] r, input logic [7:0] res, input logic [2:0] dst,
                        input logic [7:0] wa, input logic [7:0] ra, input logic co);
    ex_reg       = r;
    ex_result    = res;
    ex_dest_addr = dst;
    ex_wr_addr   = wa;
    ex_rd_addr   = ra;
    ex_cout      = co;
  endtask

  function automatic logic [0:6] bits(input bit st, input bit rw, input bit sc, input bit ie,
                                      input bit ld, input bit ifc, input bit idc);
    logic [0:6] r;
    r = '0;
    r[EX_STORE]     = st;
    r[EX_REG_WR]    = rw;
    r[EX_SAVE_COUT] = sc;
    r[EX_INV_EX]    = ie;
    r[EX_LOAD]      = ld;
    r[EX_INV_FETCH] = ifc;
    r[EX_INV_DEC]   = idc;
    return r;
  endfunction

  initial begin
    reset     = 1'b1;
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    set_ex('0, 8'h00, 3'd0, 8'h00, 8'h00, 1'b0);
    step();
    step();
    check("rst_req",   32'(mem_req),    32'd0);
    check("rst_rfwe",  32'(rf_wr_en),   32'd0);
    check("rst_carry", 32'(carry_flag), 32'd0);
    check("rst_stall", 32'(stall),      32'd0);
    check("rst_err",   32'(mem_err),    32'd0);
    reset = 1'b0;

    // ALU writeback: one-cycle latency, no stall
    set_ex(bits(0,1,0,0,0,0,0), 8'h3C, 3'd5, 8'h00, 8'h00, 1'b0);
    step();
    check("alu_we",    32'(rf_wr_en),   32'd1);
    check("alu_addr",  32'(rf_wr_addr), 32'd5);
    check("alu_data",  32'(rf_wr_data), 32'h3C);
    check("alu_stall", 32'(stall),      32'd0);
    check("alu_req",   32'(mem_req),    32'd0);
    set_ex('0, 8'h00, 3'd0, 8'h00, 8'h00, 1'b0);
    step();
    check("alu_we_pulse", 32'(rf_wr_en), 32'd0);

    // Load: ack arrives in the third request cycle
    set_ex(bits(0,0,0,0,1,0,0), 8'h00, 3'd3, 8'h00, 8'h20, 1'b0);
    step();
    for (int i = 1; i <= 3; i++) begin
      check($sformatf("ld_req_c%0d", i), 32'(mem_req), 32'd1);
      check($sformatf("ld_we_c%0d", i),  32'(mem_we),  32'd0);
      check($sformatf("ld_addr_c%0d", i), 32'(mem_addr), 32'h20);
      check($sformatf("ld_stall_c%0d", i), 32'(stall), 32'd1);
      check($sformatf("ld_rfwe_c%0d", i), 32'(rf_wr_en), 32'd0);
      if (i == 3) begin
        mem_ack   = 1'b1;
        mem_rdata = 8'hA5;
      end
      step();
    end
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    set_ex('0, 8'h00, 3'd0, 8'h00, 8'h00, 1'b0);
    check("ld_req_drop", 32'(mem_req),    32'd0);
    check("ld_wb_we",    32'(rf_wr_en),   32'd1);
    check("ld_wb_addr",  32'(rf_wr_addr), 32'd3);
    check("ld_wb_data",  32'(rf_wr_data), 32'hA5);
    check("ld_wb_stall", 32'(stall),      32'd1);
    step();
    check("ld_done_we",    32'(rf_wr_en), 32'd0);
    check("ld_done_stall", 32'(stall),    32'd0);

    // Store with load and reg_wr_en also set: store wins, no rf write
    set_ex(bits(1,1,0,0,1,0,0), 8'h11, 3'd2, 8'h40, 8'h77, 1'b0);
    step();
    check("st_req",   32'(mem_req),   32'd1);
    check("st_we",    32'(mem_we),    32'd1);
    check("st_addr",  32'(mem_addr),  32'h40);
    check("st_wdata", 32'(mem_wdata), 32'h11);
    check("st_rfwe",  32'(rf_wr_en),  32'd0);
    set_ex('0, 8'hEE, 3'd0, 8'h99, 8'h00, 1'b0);
    step();
    check("st_hold_addr",  32'(mem_addr),  32'h40);
    check("st_hold_wdata", 32'(mem_wdata), 32'h11);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("st_req_drop", 32'(mem_req),  32'd0);
    check("st_stall",    32'(stall),    32'd0);
    check("st_no_rfwe",  32'(rf_wr_en), 32'd0);
    step();
    check("st_no_rfwe2", 32'(rf_wr_en), 32'd0);

    // Invalid instructions do nothing
    set_ex(bits(1,0,1,1,0,0,0), 8'h55, 3'd1, 8'h10, 8'h00, 1'b1);
    step();
    check("inv_req",   32'(mem_req),    32'd0);
    check("inv_rfwe",  32'(rf_wr_en),   32'd0);
    check("inv_carry", 32'(carry_flag), 32'd0);
    check("inv_stall", 32'(stall),      32'd0);
    set_ex(bits(0,1,0,0,0,1,0), 8'h66, 3'd4, 8'h00, 8'h00, 1'b0);
    step();
    check("invf_rfwe", 32'(rf_wr_en), 32'd0);
    set_ex(bits(0,0,0,0,1,0,1), 8'h00, 3'd4, 8'h00, 8'h33, 1'b0);
    step();
    check("invd_req", 32'(mem_req), 32'd0);

    // Carry update and hold
    set_ex(bits(0,0,1,0,0,0,0), 8'h00, 3'd0, 8'h00, 8'h00, 1'b1);
    step();
    check("cy_set", 32'(carry_flag), 32'd1);
    set_ex(bits(0,1,0,0,0,0,0), 8'h01, 3'd7, 8'h00, 8'h00, 1'b0);
    step();
    check("cy_hold", 32'(carry_flag), 32'd1);
    set_ex(bits(0,0,1,0,0,0,0), 8'h00, 3'd0, 8'h00, 8'h00, 1'b0);
    step();
    check("cy_clear", 32'(carry_flag), 32'd0);

    // Ack while idle is ignored
    set_ex('0, 8'h00, 3'd0, 8'h00, 8'h00, 1'b0);
    mem_ack   = 1'b1;
    mem_rdata = 8'hFF;
    step();
    mem_ack = 1'b0;
    check("idle_ack_rfwe",  32'(rf_wr_en), 32'd0);
    check("idle_ack_stall", 32'(stall),    32'd0);

    // Reset during a pending load: request drops at once, late ack writes nothing
    set_ex(bits(0,0,0,0,1,0,0), 8'h00, 3'd6, 8'h00, 8'h30, 1'b0);
    step();
    check("rstm_req_pre", 32'(mem_req), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("rstm_req_async",   32'(mem_req), 32'd0);
    check("rstm_stall_async", 32'(stall),   32'd0);
    set_ex('0, 8'h00, 3'd0, 8'h00, 8'h00, 1'b0);
    step();
    reset     = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 8'h5A;
    step();
    mem_ack = 1'b0;
    check("rstm_late_rfwe", 32'(rf_wr_en), 32'd0);
    step();
    check("rstm_late_rfwe2", 32'(rf_wr_en), 32'd0);
    check("rstm_req_idle",   32'(mem_req),  32'd0);

`ifdef PL_MEMWB_TIMEOUT_EN
    // Timeout: no ack, request held 4 cycles then abandoned
    set_ex(bits(0,0,0,0,1,0,0), 8'h00, 3'd2, 8'h00, 8'h44, 1'b0);
    step();
    set_ex('0, 8'h00, 3'd0, 8'h00, 8'h00, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("to_req_c%0d", i), 32'(mem_req), 32'd1);
      check($sformatf("to_err_c%0d", i), 32'(mem_err), 32'd0);
      step();
    end
    check("to_req_drop", 32'(mem_req),  32'd0);
    check("to_err",      32'(mem_err),  32'd1);
    check("to_stall",    32'(stall),    32'd0);
    check("to_rfwe",     32'(rf_wr_en), 32'd0);
    step();
    check("to_err_sticky", 32'(mem_err), 32'd1);
`else
    check("no_timeout_err", 32'(mem_err), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
